// File: rtl/pipelined_adder_16.sv
// -----------------------------------------------------------------------------
// pipelined_adder_16
//   Pipelined add/subtract unit. One 4-bit carry-lookahead slice (fastcarry_4)
//   per pipeline stage: stage k adds operand nibble k plus the carry that
//   stage k-1 registered. Partial results and the not-yet-used upper operand
//   nibbles travel down the pipe with the carry. One beat per cycle. A single
//   global stall freezes the whole pipe while the output is held.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (= !out_valid || out_ready)
//   a, b       operands, WIDTH bits
//   cin        carry-in, used for add only
//   sub        1: a - b, 0: a + b + cin
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result, WIDTH bits
//   cout       carry out of the MSB (for sub: 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// WIDTH must be a multiple of 4 in 8..32. There are NST = WIDTH/4 stages.
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice.
//   a_i, b_i : nibble operands
//   cin_i    : carry in
//   s_o      : nibble sum
//   cout_o   : carry out
module fastcarry_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] s_o,
   output logic       cout_o
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Every carry is computed directly from generate/propagate terms,
   // so no carry ripples inside the slice.
   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s_o    = p ^ c[3:0];
   assign cout_o = c[4];
endmodule

module pipelined_adder_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NST = WIDTH / 4;

   // Operand preparation: subtraction is a + ~b + 1, and cin is ignored.
   logic [WIDTH-1:0] bx;
   logic             c0;
   logic             adv;

   assign bx = sub ? ~b : b;
   assign c0 = sub ? 1'b1 : cin;

   // Stall: the whole pipe moves only if the output slot is empty or drains.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Valid bit per stage; bit NST-1 is out_valid.
   logic [NST-1:0] vld_pipe;

   // Slice connections, one per stage.
   logic [3:0] sl_a  [NST];
   logic [3:0] sl_b  [NST];
   logic [3:0] sl_s  [NST];
   logic       sl_ci [NST];
   logic       sl_co [NST];

   // Intermediate stage registers (stages 0..NST-2). Operand copies are kept
   // full width; only the nibbles above the current stage are still consumed.
   logic [WIDTH-1:0] res_q [NST-1];
   logic [WIDTH-1:0] res_d [NST-1];
   logic [WIDTH-1:0] a_q   [NST-1];
   logic [WIDTH-1:0] a_d   [NST-1];
   logic [WIDTH-1:0] bx_q  [NST-1];
   logic [WIDTH-1:0] bx_d  [NST-1];
   logic             co_q  [NST-1];
   logic             co_d  [NST-1];

   // Last-stage registers drive the outputs directly.
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   for (genvar k = 0; k < NST; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign sl_a[k]  = a[3:0];
         assign sl_b[k]  = bx[3:0];
         assign sl_ci[k] = c0;
      end else begin : g_rest
         assign sl_a[k]  = a_q[k-1][4*k +: 4];
         assign sl_b[k]  = bx_q[k-1][4*k +: 4];
         assign sl_ci[k] = co_q[k-1];
      end

      fastcarry_4 u_fc (
         .a_i    (sl_a[k]),
         .b_i    (sl_b[k]),
         .cin_i  (sl_ci[k]),
         .s_o    (sl_s[k]),
         .cout_o (sl_co[k])
      );
   end

   always_comb begin
      for (int k = 0; k < NST-1; k++) begin
         if (k == 0) begin
            res_d[k]      = '0;
            res_d[k][3:0] = sl_s[k];
            a_d[k]        = a;
            bx_d[k]       = bx;
         end else begin
            res_d[k]           = res_q[k-1];
            res_d[k][4*k +: 4] = sl_s[k];
            a_d[k]             = a_q[k-1];
            bx_d[k]            = bx_q[k-1];
         end
         co_d[k] = sl_co[k];
      end

      sum_d                  = res_q[NST-2];
      sum_d[WIDTH-1 -: 4]    = sl_s[NST-1];
      cout_d                 = sl_co[NST-1];
      // Overflow: like-signed operands produce a result of the other sign.
      ovf_d = (sl_a[NST-1][3] == sl_b[NST-1][3]) &&
              (sl_s[NST-1][3] != sl_a[NST-1][3]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[NST-2:0], in_valid && in_ready};
         res_q    <= res_d;
         a_q      <= a_d;
         bx_q     <= bx_d;
         co_q     <= co_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign out_valid = vld_pipe[NST-1];
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_16.sv
module tb_pipelined_adder_16;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   // Expected results in acceptance order, packed as {cout, sum, ovf}.
   logic [17:0] expq [$];

   always #5 clk = ~clk;

   pipelined_adder_16 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Reference arithmetic: full-width sum of a + bx + c0.
   function automatic logic [17:0] ref_res(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic rs);
      logic [W-1:0] rbx;
      logic [W:0]   full;
      logic         rc0;
      rbx  = rs ? ~rb : rb;
      rc0  = rs ? 1'b1 : rc;
      full = {1'b0, ra} + {1'b0, rbx} + {{W{1'b0}}, rc0};
      return {full[W], full[W-1:0], (ra[W-1] == rbx[W-1]) && (full[W-1] != ra[W-1])};
   endfunction

   // Transaction-level model: push on input handshake, pop on output handshake.
   always @(posedge clk) begin
      if (rst) begin
         expq.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready === 1'b1 && expq.size() > 0)
            void'(expq.pop_front());
         if (in_valid === 1'b1 && in_ready === 1'b1)
            expq.push_back(ref_res(a, b, cin, sub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
      logic [W-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
      logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] es [5] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFE};
      logic         ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic         eo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         in_valid = 1'b1; a = ta[v]; b = tb[v]; cin = tc[v]; sub = ts[v];
         tick();
         in_valid = 1'b0;
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid cycle %0d got %b want 0", v, j, out_valid); end
            tick();
         end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got out_valid %b want 1", v, out_valid); end
         checks++; if (sum !== es[v]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", v, sum, es[v]); end
         checks++; if (cout !== ec[v]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", v, cout, ec[v]); end
         checks++; if (ovf !== eo[v]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", v, ovf, eo[v]); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] beats [8];
      logic        ev;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++)
         beats[i] = ref_res(W'(i), W'(32'h1111 * i), i[0], 1'b0);
      for (int e = 1; e <= 12; e++) begin
         if (e <= 8) begin
            in_valid = 1'b1; a = W'(e-1); b = W'(32'h1111 * (e-1)); cin = (e-1) % 2 == 1; sub = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready edge %0d got %b want 1", e, in_ready); end
         tick();
         ev = (e >= 4 && e <= 11);
         checks++; if (out_valid !== ev) begin errors++; $display("FAIL b2b_out_valid edge %0d got %b want %b", e, out_valid, ev); end
         if (ev) begin
            checks++;
            if ({cout, sum, ovf} !== beats[e-4]) begin
               errors++; $display("FAIL b2b_result beat %0d got %h want %h", e-4, {cout, sum, ovf}, beats[e-4]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] bp [4];
      int got;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         bp[i] = ref_res(a, b, cin, sub);
         tick();
      end
      // Offer a fifth beat while full; it must be refused.
      a = W'($urandom); b = W'($urandom);
      #1;
      for (int h = 0; h < 3; h++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready hold %0d got %b want 0", h, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid hold %0d got %b want 1", h, out_valid); end
         checks++;
         if ({cout, sum, ovf} !== bp[0]) begin
            errors++; $display("FAIL bp_frozen hold %0d got %h want %h", h, {cout, sum, ovf}, bp[0]);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (got >= 4) begin
               errors++; $display("FAIL bp_extra_beat got %h want none", {cout, sum, ovf});
            end else if ({cout, sum, ovf} !== bp[got]) begin
               errors++; $display("FAIL bp_order beat %0d got %h want %h", got, {cout, sum, ovf}, bp[got]);
            end
            got++;
         end
         tick();
      end
      checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         tick();
      end
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL rstmid_sum got %h want 0000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rstmid_cout got %b want 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cycle %0d got out_valid %b want 0", c, out_valid); end
      end
   endtask

   task automatic test_random_stream();
      int acc = 0;
      int cyc = 0;
      while (acc < 500 && cyc < 5000) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("FAIL rnd_stale got %h want no output", {cout, sum, ovf});
            end else if ({cout, sum, ovf} !== expq[0]) begin
               errors++; $display("FAIL rnd_result got %h want %h", {cout, sum, ovf}, expq[0]);
            end
         end
         in_valid  = $urandom_range(0, 9) < 8;
         a         = W'($urandom);
         b         = W'($urandom);
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = $urandom_range(0, 9) < 7;
         #1;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++; $display("FAIL rnd_in_ready got %b want %b", in_ready, !out_valid || out_ready);
         end
         if (in_valid && in_ready) acc++;
         tick();
         cyc++;
      end
      checks++; if (acc < 500) begin errors++; $display("FAIL rnd_timeout got %0d beats want 500", acc); end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("FAIL rnd_drain_stale got %h want no output", {cout, sum, ovf});
            end else if ({cout, sum, ovf} !== expq[0]) begin
               errors++; $display("FAIL rnd_drain_result got %h want %h", {cout, sum, ovf}, expq[0]);
            end
         end
         tick();
      end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", expq.size()); end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_adder_16.md
Name: pipelined_adder_16

Overview:
- Pipelined multi-nibble adder/subtractor built from fastcarry_4 slices, one slice per pipeline stage.
- Stage k adds nibble k of the operands plus the carry registered by stage k-1.
- Sits directly around fastcarry_4: it drives every slice's A/B/Cin and consumes every slice's S/Cout.
- Throughput is one operation per cycle; valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand width; must be a multiple of 4, legal range 8..32; number of stages NST = WIDTH/4

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used for add only
sub  input  1  1: compute a - b; 0: compute a + b + cin
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result
cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Operand preparation at input:
  - bx = sub ? ~b : b
  - c0 = sub ? 1 : cin; cin is ignored when sub = 1.
- Pipeline structure:
  - Exactly NST register stages.
  - Stage k (k = 0..NST-1) instantiates one fastcarry_4 with A = a[4k+3:4k], B = bx[4k+3:4k], Cin = carry from stage k-1 (c0 for k = 0).
  - Registered into stage k: result nibble k, its Cout, all earlier result nibbles, the unprocessed upper operand nibbles, and a valid bit.
  - The last stage also registers ovf = carry into MSB XOR carry out of MSB, computed from the final slice as (a_msb == bx_msb) && (sum_msb != a_msb).
  - sum, cout and ovf are the last-stage registers.
- Global stall: adv = !out_valid || out_ready.
  - in_ready = adv, combinational; no dependency on in_valid.
  - When adv = 1, every stage loads from its predecessor (valid bits included); stage 0 loads in_valid && in_ready.
  - When adv = 0, all stage registers hold.
  - Bubbles are not squeezed out.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NST-1 (4 cycles for WIDTH = 16), provided no stall occurs.
- Output stability: while out_valid = 1 and out_ready = 0, sum/cout/ovf hold stable.
- Full pipeline with out_ready = 0: in_ready = 0, no beat is lost or duplicated.
- Empty stages never produce out_valid.
- Reset:
  - All valid bits, sum, cout and ovf = 0.
  - in_ready = 1 in the cycle after reset, because out_valid = 0.
  - Reset mid-operation discards all in-flight beats; no output appears for them.
- Simultaneous input and output handshake on the same cycle is legal: the pipeline shifts once.
- Arithmetic wraps modulo 2^WIDTH. Results must match the full-width reference {cout, sum} = a + bx + c0 bit-exactly.

Test Plan:
- Add, carry ripple through all stages: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Subtract with borrow, cin ignored: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Repeat with cin=1 -> identical result.
- Back-to-back stream: 8 consecutive beats (a=i, b=0x1111*i, cin=i[0]) with out_ready=1 -> out_valid high for 8 consecutive cycles starting at cycle 4, results in order, in_ready stays 1.
- Backpressure: fill with 4 beats, hold out_ready=0 for 3 cycles -> in_ready=0, sum/cout/ovf frozen. Release -> the 4 results emerge in order, none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0, ovf=0 and in_ready=1 next cycle; no stale result ever appears. Also: a 500-beat random stream checked against a + bx + c0.
